// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial_read UART receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  localparam int DEF_CLKS_PER_BIT = 104;
  localparam int DEF_N_BITS       = 8;
  localparam int HALF_BIT         = DEF_CLKS_PER_BIT / 2;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/serial_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to the idle-high level.
module serial_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/serial_read.sv
// UART receiver: start-bit qualify, mid-bit sampling LSB-first, stop check, ready/ack handoff.
module serial_read
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int N_BITS       = DEF_N_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              rx_ack,
  output logic [N_BITS-1:0] rx_data,
  output logic              data_ready,
  output logic              data_valid,
  output logic              RiP,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = cnt_width(N_BITS);
  localparam int HALF  = half_bit(CLKS_PER_BIT);

  logic rx_s;

  serial_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [N_BITS-1:0]   shift_q, shift_d;
  logic [N_BITS-1:0]   rx_data_q, rx_data_d;
  logic                data_ready_q, data_ready_d;
  logic                data_valid_q, data_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  logic half_tick, last_tick, last_bit;

  assign half_tick = (cnt_q == CNT_W'(HALF - 1));
  assign last_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_idx_q == IDX_W'(N_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (half_tick) state_d = rx_s ? IDLE : DATA;
      DATA:    if (last_tick && last_bit) state_d = STOP;
      STOP:    if (last_tick) state_d = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = '0;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    data_ready_d = data_ready_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;

    unique case (state_q)
      START: begin
        cnt_d     = half_tick ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d = '0;
      end
      DATA: begin
        cnt_d = last_tick ? '0 : cnt_q + CNT_W'(1);
        if (last_tick) begin
          shift_d   = {rx_s, shift_q[N_BITS-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end
      STOP:    cnt_d = last_tick ? '0 : cnt_q + CNT_W'(1);
      default: cnt_d = '0;
    endcase

    if (rx_ack && data_ready_q) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end

    // A completing word wins over a same-cycle ack; overrun only when the old word was not taken.
    if (state_q == STOP && last_tick) begin
      if (rx_s) begin
        rx_data_d    = shift_q;
        data_valid_d = 1'b1;
        data_ready_d = 1'b1;
        if (data_ready_q && !rx_ack) overrun_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  // NOTE: the shift register and counters are reset too, keeping simulation free of X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      data_ready_q <= 1'b0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      data_ready_q <= data_ready_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    RiP        = (state_q != IDLE);
    rx_data    = rx_data_q;
    data_ready = data_ready_q;
    data_valid = data_valid_q;
    frame_err  = frame_err_q;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_serial_read.sv
// Directed bench for serial_read: framing, glitch reject, break, overrun, ack race, mid-frame reset.
module tb_serial_read;

  localparam int CPB    = 104;
  localparam int NB     = 8;
  localparam int LAT_RX = CPB / 2 + (NB + 1) * CPB + 1 + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ack = 1'b0;
  logic [NB-1:0] rx_data;
  logic          data_ready, data_valid, RiP, frame_err, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int dv_cnt = 0, fe_cnt = 0, rip_cnt = 0, dv_cycle = 0;

  serial_read #(.CLKS_PER_BIT(CPB), .N_BITS(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .data_ready (data_ready),
    .data_valid (data_valid),
    .RiP        (RiP),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt   <= dv_cnt + 1;
      dv_cycle <= cyc;
    end
    if (frame_err) fe_cnt  <= fe_cnt + 1;
    if (RiP)       rip_cnt <= rip_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one frame starting at the current negedge; leaves rx at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  int dv0, fe0, rip0, c0;

  initial begin
    // Reset state
    idle(3);
    #1;
    check("reset_rx_data", rx_data, 0);
    check("reset_flags", {data_ready, data_valid, RiP, frame_err, overrun}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    // 1: clean 0xA5 frame and its latency from the pin
    dv0 = dv_cnt; fe0 = fe_cnt; c0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("t1_dv_count", dv_cnt - dv0, 1);
    check("t1_latency", dv_cycle - c0, LAT_RX);
    check("t1_rx_data", rx_data, 8'hA5);
    check("t1_ready", data_ready, 1);
    check("t1_fe_count", fe_cnt - fe0, 0);
    check("t1_overrun", overrun, 0);
    check("t1_rip", RiP, 0);
    ack_pulse();
    check("t1_ack_ready", data_ready, 0);

    // 2: 30-cycle glitch is rejected at the half-bit sample
    dv0 = dv_cnt; fe0 = fe_cnt; rip0 = rip_cnt;
    rx = 1'b0;
    idle(30);
    rx = 1'b1;
    idle(2000);
    check("t2_rip_cycles", rip_cnt - rip0, CPB / 2);
    check("t2_dv_count", dv_cnt - dv0, 0);
    check("t2_fe_count", fe_cnt - fe0, 0);
    check("t2_rx_data", rx_data, 8'hA5);
    check("t2_rip", RiP, 0);

    // 3: low stop bit held 300 cycles -> one frame_err, BREAK until line returns
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    check("t3_fe_count", fe_cnt - fe0, 1);
    check("t3_rip_break", RiP, 1);
    idle(300 - CPB);
    check("t3_rip_held", RiP, 1);
    check("t3_fe_once", fe_cnt - fe0, 1);
    rx = 1'b1;
    idle(10);
    check("t3_rip_release", RiP, 0);
    check("t3_ready", data_ready, 0);
    check("t3_dv_count", dv_cnt - dv0, 0);
    send_frame(8'h55, 1'b1);
    idle(20);
    check("t3_next_data", rx_data, 8'h55);
    check("t3_next_dv", dv_cnt - dv0, 1);
    ack_pulse();

    // 4: back-to-back frames without ack -> overrun
    dv0 = dv_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    check("t4_rx_data", rx_data, 8'h22);
    check("t4_overrun", overrun, 1);
    check("t4_ready", data_ready, 1);
    check("t4_dv_count", dv_cnt - dv0, 2);
    ack_pulse();
    check("t4_ack_ready", data_ready, 0);
    check("t4_ack_overrun", overrun, 0);

    // 5: ack lands in the exact completion cycle of 0x7E with 0x33 pending
    send_frame(8'h33, 1'b1);
    idle(20);
    check("t5_pending", data_ready, 1);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        repeat (LAT_RX - 1) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    idle(20);
    check("t5_ready", data_ready, 1);
    check("t5_rx_data", rx_data, 8'h7E);
    check("t5_overrun", overrun, 0);

    // 6: reset during data bit 4 of 0xFF, then a clean 0x81
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (5 * CPB + 40) @(negedge clk);
        check("t6_rip_before", RiP, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rx_data", rx_data, 0);
        check("t6_rst_flags", {data_ready, data_valid, RiP, frame_err, overrun}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    dv0 = dv_cnt;
    idle(20);
    check("t6_no_dv", dv_cnt - dv0, 0);
    send_frame(8'h81, 1'b1);
    idle(20);
    check("t6_rx_data", rx_data, 8'h81);
    check("t6_ready", data_ready, 1);
    check("t6_dv_count", dv_cnt - dv0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_read.md
Name: serial_read

Overview:
- UART receiver for the FTDI serial link; the receive-side counterpart of the serial transmitter.
- Synchronizes the asynchronous rx pin and detects a start bit.
- Samples N_BITS data bits LSB-first at mid-bit, then checks the stop bit.
- Presents the byte to the fabric through a level ready flag with explicit acknowledge.

Parameters:
CLKS_PER_BIT, 104, reference clocks per serial bit (12 MHz / 115200); must be >= 8
N_BITS, 8, data bits per frame

Ports:
clk  input  1  reference clock; all logic rises on posedge
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial RX pin, asynchronous to clk, idle high
rx_ack  input  1  one-cycle pulse: consumer has taken rx_data
rx_data  output  N_BITS  last correctly framed word, LSB = first received bit
data_ready  output  1  level: rx_data holds an unacknowledged word
data_valid  output  1  one-cycle pulse when a new word is loaded
RiP  output  1  reception in progress (state != IDLE)
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  sticky: word completed while data_ready was still 1; cleared by rx_ack

Behaviour:
- Reset (async assert, sync release) sets all outputs to 0, synchronizer flops to 1 and state to IDLE.
- rx passes through a 2-FF synchronizer; rx_s is the second-stage output. All sampling uses rx_s.
- Bit counter width is ceil(log2(CLKS_PER_BIT)); it counts 0..CLKS_PER_BIT-1 and wraps to 0.
- IDLE:
  - rx_s = 0 moves to START and clears the bit counter.
  - Otherwise stay in IDLE.
- START:
  - At count CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
  - Sample 1 = glitch: return to IDLE, no outputs change.
  - Sample 0: go to DATA, clear the counter and the bit index.
- DATA:
  - At count CLKS_PER_BIT-1, shift rx_s into the shift register MSB (right shift, LSB-first) and increment the bit index.
  - After bit N_BITS-1 is sampled, go to STOP.
- STOP:
  - At count CLKS_PER_BIT-1, sample rx_s.
  - Sample 1: next cycle rx_data <= shift register, data_valid = 1 for one cycle, data_ready <= 1, go to IDLE.
  - Sample 0: frame_err = 1 for one cycle; rx_data, data_ready and data_valid are unchanged; go to BREAK.
- BREAK: wait until rx_s = 1, then go to IDLE. This keeps a held-low line from re-triggering START.
- Latency: data_valid rises (CLKS_PER_BIT/2) + (N_BITS+1)*CLKS_PER_BIT + 1 cycles after the first rx_s = 0 cycle. Add 2 cycles when measured from the rx pin.
- rx_ack while data_ready = 1 clears data_ready and overrun on the next cycle.
- rx_ack while data_ready = 0 is ignored.
- Word completes while data_ready = 1 and there is no rx_ack in the same cycle:
  - rx_data is overwritten with the new word.
  - data_valid pulses.
  - overrun <= 1.
- Word completes in the same cycle as rx_ack:
  - The completion wins and data_ready stays 1.
  - overrun is not set.
- rst_n low mid-frame aborts immediately. After release, the block resynchronizes on the next falling edge of rx_s. Trailing bits of the aborted frame may produce a frame_err; this is allowed.
- The shift register and counters are not observable outputs; their reset value is 0.

Decomposition:
- Package serial_pkg holds:
  - state enum: IDLE, START, DATA, STOP, BREAK.
  - localparam helpers: counter width via $clog2(CLKS_PER_BIT), and HALF_BIT = CLKS_PER_BIT/2.
- One natural sub-module: serial_rx_sync.
  - 2-FF synchronizer.
  - Async active-low reset to 1.
  - Ports clk, rst_n, d, q.

Test Plan:
1. rst_n released, frame 0xA5 (LSB-first bits 1,0,1,0,0,1,0,1), 104 clks/bit, stop = 1 -> exactly one data_valid pulse, rx_data = 0xA5, data_ready = 1, frame_err = 0, overrun = 0, RiP = 0 afterwards.
2. rx low for 30 cycles then high, idle 2000 cycles -> RiP pulses high then returns to IDLE before count 51; no data_valid, no frame_err, rx_data unchanged.
3. Frame 0x3C with stop bit = 0 held low 300 cycles -> frame_err pulses once, data_ready stays 0, RiP stays high until rx returns high; a following 0x55 frame is received correctly.
4. Frames 0x11 then 0x22 back-to-back, no rx_ack -> rx_data = 0x22, overrun = 1, data_ready = 1; one rx_ack pulse -> data_ready = 0, overrun = 0.
5. rx_ack asserted in the exact cycle a 0x7E frame completes (previous word pending) -> data_ready = 1, rx_data = 0x7E, overrun = 0.
6. rst_n pulsed low during data bit 4 of 0xFF -> all outputs 0 within the cycle; a clean 0x81 frame after release yields rx_data = 0x81.
